// File: rtl/qspi_tx.sv
// Quad-SPI transmitter: a nibble FIFO feeding a mode-0 serialiser that sends
// fixed-length chip-select frames and flags mid-frame underruns.
module qspi_tx #(
  parameter int CLK_DIV       = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int FRAME_NIBBLES = 32,
  parameter int CS_GAP        = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] qspi_data,
  input  logic       qspi_sending,
  output logic       qspi_ready,
  output logic       qspi_sclk,
  output logic       qspi_cs_n,
  output logic [3:0] qspi_io,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NIB_W = (FRAME_NIBBLES > 1) ? $clog2(FRAME_NIBBLES) : 1;
  localparam int GAP_W = (CS_GAP > 2) ? $clog2(CS_GAP - 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(FRAME_NIBBLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP > 1) ? CS_GAP - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    WAIT = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t           state_r;
  logic [3:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [DIV_W-1:0] div_r;
  logic [NIB_W-1:0] nib_r;
  logic [GAP_W-1:0] gap_r;
  logic             sclk_r;
  logic             cs_n_r;
  logic [3:0]       io_r;
  logic             busy_r;
  logic             done_r;
  logic             underrun_r;

  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             div_end_s;
  logic             last_nib_s;
  logic [3:0]       head_s;

  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign full_s     = (count_r == CNT_FULL);
  assign qspi_ready = !full_s && !reset;
  assign push_s     = qspi_sending && qspi_ready;
  assign head_s     = mem_r[rd_ptr_r];
  assign div_end_s  = (div_r == DIV_LAST);
  assign last_nib_s = (nib_r == NIB_LAST);

  assign qspi_sclk  = sclk_r;
  assign qspi_cs_n  = cs_n_r;
  assign qspi_io    = io_r;
  assign busy       = busy_r;
  assign frame_done = done_r;
  assign underrun   = underrun_r;

  // A nibble leaves the FIFO exactly when the serialiser loads it onto qspi_io.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE:    pop_s = !empty_s;
      HIGH:    pop_s = div_end_s && !last_nib_s && !empty_s;
      WAIT:    pop_s = !empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // FIFO storage; contents are qualified by count_r so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= qspi_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencer and registered pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      div_r      <= {DIV_W{1'b0}};
      nib_r      <= {NIB_W{1'b0}};
      gap_r      <= {GAP_W{1'b0}};
      sclk_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      io_r       <= 4'h0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            io_r    <= head_s;
            nib_r   <= {NIB_W{1'b0}};
            cs_n_r  <= 1'b0;
            div_r   <= {DIV_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= LOW;
          end
        end
        LOW: begin
          if (div_end_s) begin
            div_r   <= {DIV_W{1'b0}};
            sclk_r  <= 1'b1;
            state_r <= HIGH;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        HIGH: begin
          if (div_end_s) begin
            div_r  <= {DIV_W{1'b0}};
            sclk_r <= 1'b0;
            if (last_nib_s) begin
              // The IDLE cycle that follows supplies the final gap cycle.
              cs_n_r  <= 1'b1;
              io_r    <= 4'h0;
              done_r  <= 1'b1;
              nib_r   <= {NIB_W{1'b0}};
              gap_r   <= {GAP_W{1'b0}};
              busy_r  <= (CS_GAP > 1);
              state_r <= (CS_GAP > 1) ? GAP : IDLE;
            end else if (!empty_s) begin
              io_r    <= head_s;
              nib_r   <= nib_r + NIB_W'(1);
              state_r <= LOW;
            end else begin
              underrun_r <= 1'b1;
              state_r    <= WAIT;
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        WAIT: begin
          if (!empty_s) begin
            io_r    <= head_s;
            nib_r   <= nib_r + NIB_W'(1);
            div_r   <= {DIV_W{1'b0}};
            state_r <= LOW;
          end
        end
        GAP: begin
          if (gap_r == GAP_LAST) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            gap_r <= gap_r + GAP_W'(1);
          end
        end
        default: begin
          sclk_r  <= 1'b0;
          cs_n_r  <= 1'b1;
          io_r    <= 4'h0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
